crumb_sequencer: RTL and testbench
==================================

Name: crumb_sequencer

Overview:
- Controller for a serially chained grid of crumb cells (Game of Life cells).
- Sequences three phases: serial pattern load through the shift chain, N generation steps paced by a divider, then a display snapshot drained out as a pixel stream.
- Sits between the host/pattern source and the crumb array. It owns every array control strobe.

Parameters:
GRID_W, 8, cells per row
GRID_H, 8, rows; CELLS = GRID_W*GRID_H is the chain length
GEN_DIV, 16, clock cycles per generation (minimum 1)
GEN_W, 8, width of num_gens and gen_count

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
cmd_load  in  1  pulse: start LOAD phase
cmd_run  in  1  pulse: start RUN phase, followed by display drain
num_gens  in  GEN_W  generations to run, sampled on accepted cmd_run
load_bit  in  1  pattern bit
load_valid  in  1  load_bit valid
load_ready  out  1  sequencer accepting pattern bits
grid_en  out  1  crumb en
grid_run  out  1  crumb run (1 = apply rules, 0 = shift)
grid_shift_in  out  1  head of crumb state shift chain
grid_display  out  1  crumb display snapshot pulse
grid_display_shift_in  out  1  head of display chain, constant 0
grid_display_shift_out  in  1  tail of display chain
pix_bit  out  1  drained pixel
pix_valid  out  1  pix_bit valid
busy  out  1  state != IDLE
gen_count  out  GEN_W  generations completed in current/last run
done  out  1  one-cycle pulse at end of LOAD or DRAIN

Behaviour:
- Reset (rst=1 at clock edge): state IDLE; all outputs 0; counters 0. Reset mid-phase aborts immediately, with no done pulse.
- FSM states: IDLE, LOAD, WAIT, STEP, SNAP, DRAIN.
- IDLE:
  - cmd_load -> LOAD; cmd_run -> WAIT, latching num_gens and clearing gen_count.
  - Both asserted together: LOAD wins, cmd_run dropped.
  - Commands while busy are ignored.
  - cmd_run with latched num_gens=0 -> SNAP directly.
- LOAD:
  - load_ready=1.
  - On a cycle with load_valid=1: grid_en=1, grid_run=0, grid_shift_in=load_bit, bit counter +1.
  - Cycles with load_valid=0: grid_en=0, chain holds.
  - After the CELLS-th accepted bit: -> IDLE next cycle, done=1 for one cycle, load_ready drops in the same cycle as done.
  - First accepted bit ends up at the chain tail.
- WAIT:
  - grid_en=0; counts GEN_DIV-1 cycles, then -> STEP.
  - GEN_DIV=1 means zero wait cycles.
- STEP:
  - Exactly one cycle with grid_en=1, grid_run=1; gen_count +1.
  - -> WAIT if gen_count+1 < latched num_gens, else -> SNAP.
- Generation period is exactly GEN_DIV cycles, STEP to STEP.
- SNAP:
  - One cycle with grid_display=1, grid_en=1, grid_run=0 (latches display chain).
  - -> DRAIN.
- DRAIN:
  - CELLS cycles with grid_en=1, grid_run=0, grid_display=0, pix_valid=1.
  - pix_bit = grid_display_shift_out combinationally in each of those cycles.
  - Then -> IDLE with done=1.
  - No backpressure: the consumer must accept every pixel.
- grid_shift_in=0 outside accepted LOAD cycles. grid_display_shift_in is always 0.
- Arithmetic:
  - Counters are sized clog2(CELLS+1) and clog2(GEN_DIV).
  - gen_count saturates at 2^GEN_W-1 (unreachable since num_gens <= that).
  - gen_count holds its final value in IDLE until the next accepted cmd_run.
- Total RUN latency, cmd_run edge to done: num_gens*GEN_DIV + 1 + CELLS + 1 cycles.

Optional Feature:
- Macro CRUMB_SEQ_ABORT_EN.
- Defined:
  - Adds input cmd_abort (1) and output aborted (1).
  - cmd_abort high in any non-IDLE state -> IDLE on the next edge, all grid strobes 0, aborted=1 for one cycle, done not pulsed, gen_count holds.
  - cmd_abort in IDLE: no effect.
  - cmd_abort has priority over phase completion in the same cycle.
- Undefined: neither port exists; phases always run to completion.

Test Plan:
- LOAD 16 bits (GRID 4x4) 1,0,1,1,… with load_valid gap of 3 cycles after bit 5 -> grid_en high on exactly 16 cycles, 0 during gap; done 1 cycle after 16th bit; load_ready 0 afterwards.
- cmd_run num_gens=3, GEN_DIV=4 -> grid_run pulses at cycles 4,8,12 after cmd_run; gen_count 1,2,3; SNAP at 13; pix_valid for 16 cycles; done at cycle 30.
- cmd_run num_gens=0 -> no grid_run pulse, SNAP next cycle, 16 pix_valid, gen_count=0.
- cmd_load and cmd_run same cycle in IDLE -> LOAD entered; cmd_run during LOAD ignored (no grid_run pulse).
- rst asserted mid-DRAIN at pixel 7 -> next cycle all outputs 0, busy 0, no done; subsequent cmd_run works normally.
- With CRUMB_SEQ_ABORT_EN: cmd_abort in WAIT after gen 2 of 5 -> aborted pulse, gen_count=2, no SNAP, no done.

Source files
------------

// File: rtl/crumb_sequencer.sv
// crumb_sequencer: phase controller for a serially chained crumb (Game of Life) grid.
//   LOAD : shifts CELLS pattern bits into the state chain (first bit ends at the tail)
//   RUN  : WAIT/STEP loop, one generation every GEN_DIV cycles, num_gens times
//   SNAP : one-cycle display snapshot, then DRAIN streams CELLS pixels out
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   cmd_load, cmd_run, num_gens  host commands (accepted only in IDLE, load wins)
//   load_bit/valid/ready         pattern source handshake
//   grid_*                       every control strobe of the crumb array
//   pix_bit, pix_valid           drained pixel stream, no backpressure
//   busy, gen_count, done        status; done pulses after LOAD or DRAIN
// Optional: define CRUMB_SEQ_ABORT_EN to add cmd_abort / aborted.
module crumb_sequencer #(
    parameter int GRID_W  = 8,
    parameter int GRID_H  = 8,
    parameter int GEN_DIV = 16,
    parameter int GEN_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_load,
    input  logic             cmd_run,
    input  logic [GEN_W-1:0] num_gens,
    input  logic             load_bit,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             grid_en,
    output logic             grid_run,
    output logic             grid_shift_in,
    output logic             grid_display,
    output logic             grid_display_shift_in,
    input  logic             grid_display_shift_out,
    output logic             pix_bit,
    output logic             pix_valid,
    output logic             busy,
    output logic [GEN_W-1:0] gen_count,
`ifdef CRUMB_SEQ_ABORT_EN
    output logic             done,
    input  logic             cmd_abort,
    output logic             aborted
`else
    output logic             done
`endif
);
    localparam int CELLS = GRID_W * GRID_H;
    localparam int CW    = $clog2(CELLS + 1);
    localparam int DW    = (GEN_DIV > 1) ? $clog2(GEN_DIV) : 1;

    localparam logic [CW-1:0]    LAST_CELL = CW'(CELLS - 1);
    // WAIT occupies GEN_DIV-1 cycles, so its counter runs 0..GEN_DIV-2
    localparam logic [DW-1:0]    LAST_WAIT = DW'((GEN_DIV > 1) ? GEN_DIV - 2 : 0);
    localparam logic [GEN_W-1:0] GEN_MAX   = '1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_STEP  = 3'd3;
    localparam logic [2:0] S_SNAP  = 3'd4;
    localparam logic [2:0] S_DRAIN = 3'd5;
    // with GEN_DIV=1 there is no wait at all: steps run back to back
    localparam logic [2:0] S_GEN   = (GEN_DIV > 1) ? S_WAIT : S_STEP;

    logic [2:0]       state;
    logic [CW-1:0]    cell_cnt;
    logic [DW-1:0]    div_cnt;
    logic [GEN_W-1:0] gens_lat;
    logic [GEN_W:0]   gen_next;
    logic             abort_now;

`ifdef CRUMB_SEQ_ABORT_EN
    assign abort_now = cmd_abort && (state != S_IDLE);
`else
    assign abort_now = 1'b0;
`endif

    assign gen_next              = {1'b0, gen_count} + {{GEN_W{1'b0}}, 1'b1};
    assign busy                  = (state != S_IDLE);
    assign grid_display_shift_in = 1'b0;

    always_comb begin
        load_ready    = 1'b0;
        grid_en       = 1'b0;
        grid_run      = 1'b0;
        grid_shift_in = 1'b0;
        grid_display  = 1'b0;
        pix_valid     = 1'b0;
        pix_bit       = 1'b0;
        case (state)
            S_LOAD: begin
                load_ready    = 1'b1;
                grid_en       = load_valid;
                grid_shift_in = load_valid & load_bit;
            end
            S_STEP: begin
                grid_en  = 1'b1;
                grid_run = 1'b1;
            end
            S_SNAP: begin
                grid_en      = 1'b1;
                grid_display = 1'b1;
            end
            S_DRAIN: begin
                grid_en   = 1'b1;
                pix_valid = 1'b1;
                pix_bit   = grid_display_shift_out;
            end
            default: ;
        endcase
        // an abort silences the array immediately so nothing moves in the abort cycle
        if (abort_now) begin
            grid_en       = 1'b0;
            grid_run      = 1'b0;
            grid_shift_in = 1'b0;
            grid_display  = 1'b0;
            pix_valid     = 1'b0;
            pix_bit       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cell_cnt  <= '0;
            div_cnt   <= '0;
            gens_lat  <= '0;
            gen_count <= '0;
            done      <= 1'b0;
`ifdef CRUMB_SEQ_ABORT_EN
            aborted   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef CRUMB_SEQ_ABORT_EN
            aborted <= 1'b0;
            if (abort_now) begin
                state   <= S_IDLE;
                aborted <= 1'b1;
            end else
`endif
            case (state)
                S_IDLE: begin
                    if (cmd_load) begin
                        state    <= S_LOAD;
                        cell_cnt <= '0;
                    end else if (cmd_run) begin
                        gens_lat  <= num_gens;
                        gen_count <= '0;
                        div_cnt   <= '0;
                        state     <= (num_gens == '0) ? S_SNAP : S_GEN;
                    end
                end
                S_LOAD: begin
                    if (load_valid) begin
                        if (cell_cnt == LAST_CELL) begin
                            state <= S_IDLE;
                            done  <= 1'b1;
                        end else begin
                            cell_cnt <= cell_cnt + CW'(1);
                        end
                    end
                end
                S_WAIT: begin
                    if (div_cnt == LAST_WAIT) begin
                        state   <= S_STEP;
                        div_cnt <= '0;
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end
                S_STEP: begin
                    if (gen_count != GEN_MAX) gen_count <= gen_next[GEN_W-1:0];
                    div_cnt <= '0;
                    state   <= (gen_next < {1'b0, gens_lat}) ? S_GEN : S_SNAP;
                end
                S_SNAP: begin
                    state    <= S_DRAIN;
                    cell_cnt <= '0;
                end
                S_DRAIN: begin
                    if (cell_cnt == LAST_CELL) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end else begin
                        cell_cnt <= cell_cnt + CW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_crumb_sequencer.sv
// Randomized bench for crumb_sequencer on a 4x4 grid with GEN_DIV=4.
// Expected behaviour is computed per cycle from the phase timing arithmetic
// (cycle k after an accepted cmd_run) rather than from any state machine.
module tb_crumb_sequencer;
    localparam int GW = 4, GH = 4, GD = 4, GEW = 8;
    localparam int CELLS = GW * GH;

    logic clk = 1'b0;
    logic rst, cmd_load, cmd_run, load_bit, load_valid, grid_display_shift_out;
    logic [GEW-1:0] num_gens;
    logic load_ready, grid_en, grid_run, grid_shift_in, grid_display;
    logic grid_display_shift_in, pix_bit, pix_valid, busy, done;
    logic [GEW-1:0] gen_count;
`ifdef CRUMB_SEQ_ABORT_EN
    logic cmd_abort, aborted;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    crumb_sequencer #(.GRID_W(GW), .GRID_H(GH), .GEN_DIV(GD), .GEN_W(GEW)) dut (
        .clk(clk), .rst(rst), .cmd_load(cmd_load), .cmd_run(cmd_run),
        .num_gens(num_gens), .load_bit(load_bit), .load_valid(load_valid),
        .load_ready(load_ready), .grid_en(grid_en), .grid_run(grid_run),
        .grid_shift_in(grid_shift_in), .grid_display(grid_display),
        .grid_display_shift_in(grid_display_shift_in),
        .grid_display_shift_out(grid_display_shift_out),
        .pix_bit(pix_bit), .pix_valid(pix_valid), .busy(busy),
        .gen_count(gen_count),
`ifdef CRUMB_SEQ_ABORT_EN
        .done(done), .cmd_abort(cmd_abort), .aborted(aborted)
`else
        .done(done)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        cmd_load = 0; cmd_run = 0; num_gens = '0; load_bit = 0; load_valid = 0;
        grid_display_shift_out = 0;
`ifdef CRUMB_SEQ_ABORT_EN
        cmd_abort = 0;
`endif
    endtask

    task automatic check_quiet(input string ph);
        check({ph, "_en"}, grid_en, 0);
        check({ph, "_run"}, grid_run, 0);
        check({ph, "_sin"}, grid_shift_in, 0);
        check({ph, "_disp"}, grid_display, 0);
        check({ph, "_pv"}, pix_valid, 0);
        check({ph, "_pix"}, pix_bit, 0);
        check({ph, "_ready"}, load_ready, 0);
        check({ph, "_busy"}, busy, 0);
        check({ph, "_dsin"}, grid_display_shift_in, 0);
    endtask

    // Load CELLS bits with random valid gaps; a 3-cycle gap follows bit gap_after.
    task automatic do_load(input bit with_run, input int gap_after);
        int acc = 0, cyc = 0, gap = 0;
        logic lv;
        @(negedge clk);
        idle_inputs();
        cmd_load = 1; cmd_run = with_run; num_gens = 8'd3;
        #1 check("ld_cmd_busy", busy, 0);
        while (acc < CELLS) begin
            @(negedge clk);
            cmd_load = ($urandom_range(0, 3) == 0);
            cmd_run  = ($urandom_range(0, 3) == 0);
            num_gens = 8'($urandom);
            if (gap > 0) begin
                lv = 0;
                gap--;
            end else begin
                lv = ($urandom_range(0, 3) != 0) || (cyc > 40);
            end
            load_valid = lv;
            load_bit   = 1'($urandom);
            #1;
            check("ld_ready", load_ready, 1);
            check("ld_en", grid_en, lv);
            check("ld_run", grid_run, 0);
            check("ld_sin", grid_shift_in, lv & load_bit);
            check("ld_busy", busy, 1);
            check("ld_done", done, 0);
            check("ld_pv", pix_valid, 0);
            if (lv) begin
                acc++;
                if (acc == gap_after) gap = 3;
            end
            cyc++;
        end
        @(negedge clk);
        idle_inputs();
        #1;
        check("ld_end_done", done, 1);
        check_quiet("ld_end");
        @(negedge clk);
        #1 check("ld_done_once", done, 0);
    endtask

    // cmd_run with n generations; optionally reset at cycle rst_k or abort at cycle abort_k.
    task automatic do_run(input int n, input int rst_k, input int abort_k);
        int total;
        int gc;
        bit run_e, snap_e, pv_e;
        total = n * GD + CELLS + 2;
        @(negedge clk);
        idle_inputs();
        cmd_run = 1; num_gens = GEW'(n);
        #1 check("run_cmd_busy", busy, 0);
        for (int k = 1; k <= total; k++) begin
            @(negedge clk);
            cmd_run    = (k < total) && ($urandom_range(0, 7) == 0);
            cmd_load   = (k < total) && ($urandom_range(0, 7) == 0);
            num_gens   = 8'($urandom);
            load_valid = 1'($urandom);
            load_bit   = 1'($urandom);
            grid_display_shift_out = 1'($urandom);
`ifdef CRUMB_SEQ_ABORT_EN
            cmd_abort = (k == abort_k);
`endif
            #1;
            run_e  = (k % GD == 0) && (k <= n * GD);
            snap_e = (k == n * GD + 1);
            pv_e   = (k >= n * GD + 2) && (k <= n * GD + CELLS + 1);
            gc     = ((k - 1) / GD < n) ? (k - 1) / GD : n;
            if (k != abort_k) begin
                check("run_en", grid_en, run_e | snap_e | pv_e);
                check("run_run", grid_run, run_e);
                check("run_disp", grid_display, snap_e);
                check("run_pv", pix_valid, pv_e);
                check("run_pix", pix_bit, pv_e & grid_display_shift_out);
                check("run_sin", grid_shift_in, 0);
                check("run_ready", load_ready, 0);
                check("run_busy", busy, k < total);
                check("run_done", done, k == total);
                check("run_gc", gen_count, gc);
            end
            if (k == rst_k) begin
                rst = 1;
                @(negedge clk);
                rst = 0;
                idle_inputs();
                #1;
                check_quiet("rst");
                check("rst_done", done, 0);
                check("rst_gc", gen_count, 0);
                return;
            end
`ifdef CRUMB_SEQ_ABORT_EN
            if (k == abort_k) begin
                @(negedge clk);
                idle_inputs();
                #1;
                check("ab_aborted", aborted, 1);
                check("ab_done", done, 0);
                check("ab_gc", gen_count, gc);
                check_quiet("ab");
                @(negedge clk);
                #1 check("ab_once", aborted, 0);
                check("ab_hold_idle", busy, 0);
                return;
            end
`endif
        end
        @(negedge clk);
        idle_inputs();
        #1;
        check("run_after_done", done, 0);
        check("run_after_gc", gen_count, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rst = 1;
        repeat (3) @(negedge clk);
        #1;
        check_quiet("reset");
        check("reset_done", done, 0);
        check("reset_gc", gen_count, 0);
        @(negedge clk);
        rst = 0;

        do_load(1'b0, 5);
        do_run(3, -1, -1);
        do_run(0, -1, -1);
        do_load(1'b1, 0);
        do_run(2, 2 * GD + 1 + 7, -1);
        do_run(1, -1, -1);
        do_run(20, -1, -1);
        repeat (8) begin
            if ($urandom_range(0, 2) == 0) do_load(1'b0, int'($urandom_range(1, CELLS)));
            else do_run(int'($urandom_range(0, 6)), -1, -1);
        end
`ifdef CRUMB_SEQ_ABORT_EN
        do_run(5, -1, 2 * GD + 2);
        do_run(2, -1, -1);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
